// File: rtl/mips_mem_pkg.sv
// Shared constants for the mips data-side memory/MMIO responder.
package mips_mem_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [7:0] IO_CYCLES = 8'h00;
    localparam logic [7:0] IO_TXDATA = 8'h04;
    localparam logic [7:0] IO_STATUS = 8'h08;

    localparam int unsigned ST_EMPTY    = 8;
    localparam int unsigned ST_FULL     = 9;
    localparam int unsigned ST_OVERFLOW = 10;
    localparam int unsigned ST_MISALIGN = 11;

    typedef enum logic [1:0] {
        REG_CYCLES,
        REG_TXDATA,
        REG_STATUS,
        REG_NONE
    } io_reg_e;

    // Word offset within the I/O page to register select.
    function automatic io_reg_e decode_io(input logic [5:0] word_off);
        io_reg_e sel;
        sel = REG_NONE;
        if (word_off == IO_CYCLES[7:2]) sel = REG_CYCLES;
        else if (word_off == IO_TXDATA[7:2]) sel = REG_TXDATA;
        else if (word_off == IO_STATUS[7:2]) sel = REG_STATUS;
        return sel;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO with registered storage; head is read straight from the array (no fall-through).
module tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic [7:0]                      data_i,
    output logic [7:0]                      data_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o,
    output logic                            empty_o,
    output logic                            full_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus I/O page (cycle counter, TX FIFO, status) for the single-cycle mips core.
module dmem_mmio
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [DEPTH];
    logic [AW-1:0] ram_idx;

    logic          is_io;
    io_reg_e       io_sel;
    logic          misaligned_st;
    logic          store_ok;
    logic          wr_ram, wr_cycles, wr_tx, wr_status;

    logic [31:0]   cycles_q, cycles_d;
    logic          ovf_q, ovf_d;
    logic          mis_q, mis_d;

    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    logic [7:0]    fifo_head;

    assign is_io   = (aluout[31:8] == IO_BASE[31:8]);
    assign io_sel  = decode_io(aluout[7:2]);
    assign ram_idx = aluout[AW+1:2];

    assign misaligned_st = memwrite && (aluout[1:0] != 2'b00);
    assign store_ok      = memwrite && (aluout[1:0] == 2'b00);
    assign wr_ram    = store_ok && !is_io;
    assign wr_cycles = store_ok && is_io && (io_sel == REG_CYCLES);
    assign wr_tx     = store_ok && is_io && (io_sel == REG_TXDATA);
    assign wr_status = store_ok && is_io && (io_sel == REG_STATUS);

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;
    assign fifo_pop  = out_valid && out_ready;

    tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (wr_tx),
        .pop_i   (fifo_pop),
        .data_i  (writedata[7:0]),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Set events take priority over a same-cycle write-1-to-clear.
    always_comb begin
        cycles_d = cycles_q + 32'd1;
        ovf_d    = ovf_q;
        mis_d    = mis_q;
        if (wr_cycles) cycles_d = writedata;
        if (wr_status && writedata[ST_OVERFLOW]) ovf_d = 1'b0;
        if (wr_status && writedata[ST_MISALIGN]) mis_d = 1'b0;
        if (wr_tx && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (misaligned_st) mis_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            cycles_q <= cycles_d;
            ovf_q    <= ovf_d;
            mis_q    <= mis_d;
        end
    end

    // RAM has no reset and survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (wr_ram) ram[ram_idx] <= writedata;
    end

    always_comb begin
        readdata = '0;
        if (!is_io) begin
            readdata = ram[ram_idx];
        end else begin
            unique case (io_sel)
                REG_CYCLES: readdata = cycles_q;
                REG_STATUS: begin
                    readdata[7:0]       = 8'(fifo_count);
                    readdata[ST_EMPTY]    = fifo_empty;
                    readdata[ST_FULL]     = fifo_full;
                    readdata[ST_OVERFLOW] = ovf_q;
                    readdata[ST_MISALIGN] = mis_q;
                end
                default: readdata = '0;
            endcase
        end
    end

endmodule
